// File: rtl/checker_pkg.sv
// Shared constants for the checkers board renderer: cell layout, legal-move
// bus format, 640x480@60 raster timing and the palette.
package checker_pkg;

  localparam int CELL_OCC  = 2;
  localparam int CELL_RED  = 1;
  localparam int CELL_KING = 0;

  localparam int LM_W = 7;
  localparam int LM_N = 4;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_TOTAL   = 525;

  localparam int BAR_H0 = 16;
  localparam int BAR_H1 = 63;
  localparam int BAR_V0 = 16;
  localparam int BAR_V1 = 463;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK  = rgb_t'(24'h000000);
  localparam rgb_t C_CURSOR = rgb_t'(24'hFFFF00);
  localparam rgb_t C_LEGAL  = rgb_t'(24'h00C000);
  localparam rgb_t C_KING   = rgb_t'(24'hFFB000);
  localparam rgb_t C_RED    = rgb_t'(24'hC00000);
  localparam rgb_t C_WHITE  = rgb_t'(24'hF0F0F0);
  localparam rgb_t C_DARK   = rgb_t'(24'h603010);
  localparam rgb_t C_LIGHT  = rgb_t'(24'hE0C090);

  // Square of a signed 7-bit offset; |a| never exceeds 63 so 12 bits hold it.
  function automatic logic [11:0] sq_off(input logic [6:0] a);
    logic [5:0] mag;
    mag = a[6] ? 6'(-a) : a[5:0];
    return 12'(mag) * 12'(mag);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters, raw sync/visible flags and divider-free square/offset
// counters for the board grid.
module vga_timing
  import checker_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_TOT = H_TOTAL,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_TOT = V_TOTAL,
  parameter int H_ORG = 80,
  parameter int SQ    = 60
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       visible,
  output logic [2:0] sx,
  output logic [2:0] sy,
  output logic [5:0] dx,
  output logic [5:0] dy,
  output logic       in_board
);

  localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0] HS_0    = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_1    = 10'(H_VIS + H_FP + H_SW);
  localparam logic [9:0] VS_0    = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_1    = 10'(V_VIS + V_FP + V_SW);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] BRD_H0  = 10'(H_ORG);
  localparam logic [9:0] BRD_H1  = 10'(H_ORG + 8 * SQ);
  localparam logic [9:0] BRD_V1  = 10'(8 * SQ);
  localparam logic [5:0] SQ_LAST = 6'(SQ - 1);

  logic [9:0] h_reg, h_next, v_reg, v_next;
  logic [2:0] sx_reg, sx_next, sy_reg, sy_next;
  logic [5:0] dx_reg, dx_next, dy_reg, dy_next;

  always_comb begin
    h_next  = (h_reg == H_LAST) ? '0 : h_reg + 10'd1;
    v_next  = v_reg;
    dx_next = dx_reg;
    sx_next = sx_reg;
    dy_next = dy_reg;
    sy_next = sy_reg;
    if (h_reg == H_LAST)
      v_next = (v_reg == V_LAST) ? '0 : v_reg + 10'd1;

    // Column counters restart exactly as the pixel entering the board arrives.
    if (h_next == BRD_H0) begin
      dx_next = '0;
      sx_next = '0;
    end else if (dx_reg == SQ_LAST) begin
      dx_next = '0;
      sx_next = sx_reg + 3'd1;
    end else begin
      dx_next = dx_reg + 6'd1;
    end

    if (h_reg == H_LAST) begin
      if (v_next == '0) begin
        dy_next = '0;
        sy_next = '0;
      end else if (dy_reg == SQ_LAST) begin
        dy_next = '0;
        sy_next = sy_reg + 3'd1;
      end else begin
        dy_next = dy_reg + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg  <= '0;
      v_reg  <= '0;
      sx_reg <= '0;
      sy_reg <= '0;
      dx_reg <= '0;
      dy_reg <= '0;
    end else begin
      h_reg  <= h_next;
      v_reg  <= v_next;
      sx_reg <= sx_next;
      sy_reg <= sy_next;
      dx_reg <= dx_next;
      dy_reg <= dy_next;
    end
  end

  assign h        = h_reg;
  assign v        = v_reg;
  assign sx       = sx_reg;
  assign sy       = sy_reg;
  assign dx       = dx_reg;
  assign dy       = dy_reg;
  assign hs_raw   = !((h_reg >= HS_0) && (h_reg < HS_1));
  assign vs_raw   = !((v_reg >= VS_0) && (v_reg < VS_1));
  assign visible  = (h_reg < H_VIS_L) && (v_reg < V_VIS_L);
  assign in_board = (h_reg >= BRD_H0) && (h_reg < BRD_H1) && (v_reg < BRD_V1);

endmodule

// File: rtl/checker_board_renderer.sv
// Draws the checkers board from a per-frame snapshot of the game state onto
// a VGA raster; two pipeline stages, syncs delayed to match.
module checker_board_renderer
  import checker_pkg::*;
#(
  parameter int H_ORG   = 80,
  parameter int SQ      = 60,
  parameter int R_PIECE = 22,
  parameter int R_KING  = 8,
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FP    = H_FRONT,
  parameter int H_SW    = H_SYNC,
  parameter int H_TOT   = H_TOTAL,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FP    = V_FRONT,
  parameter int V_SW    = V_SYNC,
  parameter int V_TOT   = V_TOTAL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [191:0] serialized_board,
  input  logic [27:0]  legal_move,
  input  logic [5:0]   select_loc,
  input  logic         turn,
  output logic [7:0]   vga_r,
  output logic [7:0]   vga_g,
  output logic [7:0]   vga_b,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic         vga_blank_n
);

  localparam logic [9:0]  V_SNAP  = 10'(V_VIS);
  localparam logic [5:0]  HALF    = 6'(SQ / 2);
  localparam logic [5:0]  EDGE_HI = 6'(SQ - 3);
  localparam logic [12:0] RP2     = 13'(R_PIECE * R_PIECE);
  localparam logic [12:0] RK2     = 13'(R_KING * R_KING);

  logic [9:0] h, v;
  logic       hs_raw, vs_raw, visible, in_board;
  logic [2:0] sx, sy;
  logic [5:0] dx, dy;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_TOT(H_TOT),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_TOT(V_TOT),
    .H_ORG(H_ORG), .SQ(SQ)
  ) u_timing (
    .clk(clk), .rst(rst), .h(h), .v(v),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .visible(visible),
    .sx(sx), .sy(sy), .dx(dx), .dy(dy), .in_board(in_board)
  );

  // Frame snapshot, taken during vertical blanking so a frame never tears.
  logic [191:0] board_reg;
  logic [27:0]  legal_reg;
  logic [5:0]   sel_reg;
  logic         turn_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      board_reg <= '0;
      legal_reg <= '0;
      sel_reg   <= '0;
      turn_reg  <= 1'b0;
    end else if (h == '0 && v == V_SNAP) begin
      board_reg <= serialized_board;
      legal_reg <= legal_move;
      sel_reg   <= select_loc;
      turn_reg  <= turn;
    end
  end

  logic [2:0] cells [64];
  for (genvar gi = 0; gi < 64; gi++) begin : g_cells
    assign cells[gi] = board_reg[3*gi +: 3];
  end

  logic [2:0] y_cur;
  logic       bar_cur;
  assign y_cur   = 3'd7 - sy;
  assign bar_cur = (h >= 10'(BAR_H0)) && (h <= 10'(BAR_H1)) &&
                   (v >= 10'(BAR_V0)) && (v <= 10'(BAR_V1));

  // Stage 1: geometry, region flags and the cell under the pixel.
  logic       vis_s1, hs_s1, vs_s1, board_s1, bar_s1;
  logic [2:0] sx_s1, y_s1, cell_s1;
  logic [5:0] dx_s1, dy_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vis_s1   <= 1'b0;
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      board_s1 <= 1'b0;
      bar_s1   <= 1'b0;
      sx_s1    <= '0;
      y_s1     <= '0;
      cell_s1  <= '0;
      dx_s1    <= '0;
      dy_s1    <= '0;
    end else begin
      vis_s1   <= visible;
      hs_s1    <= hs_raw;
      vs_s1    <= vs_raw;
      board_s1 <= in_board;
      bar_s1   <= bar_cur;
      sx_s1    <= sx;
      y_s1     <= y_cur;
      cell_s1  <= cells[{sx, y_cur}];
      dx_s1    <= dx;
      dy_s1    <= dy;
    end
  end

  logic [LM_N-1:0] legal_hit;
  for (genvar gi = 0; gi < LM_N; gi++) begin : g_legal
    assign legal_hit[gi] = legal_reg[gi*LM_W + LM_W - 1] &&
                           (legal_reg[gi*LM_W +: LM_W-1] == {sx_s1, y_s1});
  end

  logic [6:0]  ox, oy;
  logic [12:0] d2;
  logic        border, cursor, legal, king_px, piece_px;
  rgb_t        rgb_next;

  always_comb begin
    ox       = {1'b0, dx_s1} - {1'b0, HALF};
    oy       = {1'b0, dy_s1} - {1'b0, HALF};
    d2       = {1'b0, sq_off(ox)} + {1'b0, sq_off(oy)};
    border   = (dx_s1 < 6'd3) || (dx_s1 >= EDGE_HI) ||
               (dy_s1 < 6'd3) || (dy_s1 >= EDGE_HI);
    cursor   = border && ({sx_s1, y_s1} == sel_reg);
    legal    = border && (|legal_hit);
    king_px  = cell_s1[CELL_OCC] && cell_s1[CELL_KING] && (d2 <= RK2);
    piece_px = cell_s1[CELL_OCC] && (d2 <= RP2);
    rgb_next = C_BLACK;
    if (vis_s1) begin
      if (board_s1) begin
        if (cursor)                 rgb_next = C_CURSOR;
        else if (legal)             rgb_next = C_LEGAL;
        else if (king_px)           rgb_next = C_KING;
        else if (piece_px)          rgb_next = cell_s1[CELL_RED] ? C_RED : C_WHITE;
        else if (sx_s1[0] == y_s1[0]) rgb_next = C_DARK;
        else                        rgb_next = C_LIGHT;
      end else if (bar_s1) begin
        rgb_next = turn_reg ? C_RED : C_WHITE;
      end
    end
  end

  // Stage 2: final colour plus syncs aligned with it.
  rgb_t rgb_reg;
  logic hs_reg, vs_reg, blank_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_reg   <= C_BLACK;
      hs_reg    <= 1'b1;
      vs_reg    <= 1'b1;
      blank_reg <= 1'b0;
    end else begin
      rgb_reg   <= rgb_next;
      hs_reg    <= hs_s1;
      vs_reg    <= vs_s1;
      blank_reg <= vis_s1;
    end
  end

  assign vga_r       = rgb_reg.r;
  assign vga_g       = rgb_reg.g;
  assign vga_b       = rgb_reg.b;
  assign vga_hs      = hs_reg;
  assign vga_vs      = vs_reg;
  assign vga_blank_n = blank_reg;

endmodule

// File: tb/tb_checker_board_renderer.sv
// Directed bench: a full-size renderer for raster timing and a shrunken-geometry
// instance (short frames) for snapshot and drawing behaviour.
module tb_checker_board_renderer;

  logic         clk = 1'b0;
  logic         rst;
  logic [191:0] serialized_board;
  logic [27:0]  legal_move;
  logic [5:0]   select_loc;
  logic         turn;

  logic [7:0] r_d, g_d, b_d, r_s, g_s, b_s;
  logic       hs_d, vs_d, bn_d, hs_s, vs_s, bn_s;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always #20 clk = ~clk;

  checker_board_renderer dut (
    .clk(clk), .rst(rst), .serialized_board(serialized_board),
    .legal_move(legal_move), .select_loc(select_loc), .turn(turn),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
    .vga_hs(hs_d), .vga_vs(vs_d), .vga_blank_n(bn_d)
  );

  // 12-px squares, board at h 64..159 / v 0..95, 176x100 raster.
  checker_board_renderer #(
    .H_ORG(64), .SQ(12), .R_PIECE(4), .R_KING(1),
    .H_VIS(160), .H_FP(4), .H_SW(8), .H_TOT(176),
    .V_VIS(96), .V_FP(2), .V_SW(2), .V_TOT(100)
  ) dut_s (
    .clk(clk), .rst(rst), .serialized_board(serialized_board),
    .legal_move(legal_move), .select_loc(select_loc), .turn(turn),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bn_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int unsigned k);
    while (cyc < k) tick();
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s cyc %0d observed %h expected %h", tag, cyc, obs, exp);
  endtask

  // Edge count after release at which pixel (h,v) is on the outputs.
  function automatic int unsigned kd(input int hh, input int vv);
    return vv * 800 + hh + 2;
  endfunction
  function automatic int unsigned ks(input int frame, input int hh, input int vv);
    return frame * 17600 + vv * 176 + hh + 2;
  endfunction

  function automatic logic [191:0] opening();
    logic [191:0] b;
    b = '0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        if (((x + y) % 2) == 0) begin
          if (y < 3)      b[3*(x*8+y) +: 3] = 3'b110;
          else if (y > 4) b[3*(x*8+y) +: 3] = 3'b100;
        end
    return b;
  endfunction

  logic [191:0] board1, board2;

  initial begin
    board1 = opening();
    board1[3*(3*8+3) +: 3] = 3'b111;
    board2 = board1;
    board2[2:0] = 3'b000;

    rst              = 1'b1;
    serialized_board = board1;
    legal_move       = {21'd0, 1'b1, 3'd2, 3'd3};
    select_loc       = {3'd2, 3'd3};
    turn             = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_sync_d", {21'd0, hs_d, vs_d, bn_d}, 24'h000006);
    chk("rst_sync_s", {21'd0, hs_s, vs_s, bn_s}, 24'h000006);
    chk("rst_rgb_d", {r_d, g_d, b_d}, 24'h000000);
    chk("rst_rgb_s", {r_s, g_s, b_s}, 24'h000000);
    rst = 1'b0;
    cyc = 0;

    run_to(kd(639, 0)); chk("blank_h639", {23'd0, bn_d}, 24'd1);
    run_to(kd(640, 0)); chk("blank_h640", {23'd0, bn_d}, 24'd0);
    run_to(kd(655, 0)); chk("hs_h655", {23'd0, hs_d}, 24'd1);
    run_to(kd(656, 0)); chk("hs_fall", {23'd0, hs_d}, 24'd0);
    run_to(kd(751, 0)); chk("hs_h751", {23'd0, hs_d}, 24'd0);
    run_to(kd(752, 0)); chk("hs_rise", {23'd0, hs_d}, 24'd1);
    run_to(kd(655, 1)); chk("hs_l1_h655", {23'd0, hs_d}, 24'd1);
    run_to(kd(656, 1)); chk("hs_l1_fall", {23'd0, hs_d}, 24'd0);

    // Frame 0: snapshot still reset, inputs already loaded have no effect.
    run_to(ks(0, 20, 20));  chk("s_bar_f0", {r_s, g_s, b_s}, 24'hF0F0F0);
    run_to(ks(0, 70, 90));  chk("s_sq00_f0", {r_s, g_s, b_s}, 24'h603010);
    run_to(kd(20, 20));     chk("d_bar_f0", {r_d, g_d, b_d}, 24'hF0F0F0);
    run_to(ks(0, 175, 97)); chk("s_vs_v97", {23'd0, vs_s}, 24'd1);
    run_to(ks(0, 0, 98));   chk("s_vs_v98", {23'd0, vs_s}, 24'd0);

    // Frame 1: opening board with king at (3,3), cursor and legal on (2,3).
    run_to(ks(1, 70, 6));   chk("s_sq07_empty", {r_s, g_s, b_s}, 24'hE0C090);
    run_to(ks(1, 82, 6));   chk("s_white_17", {r_s, g_s, b_s}, 24'hF0F0F0);
    run_to(ks(1, 20, 20));  chk("s_bar_red", {r_s, g_s, b_s}, 24'hC00000);
    run_to(kd(110, 30));    chk("d_sq07_light", {r_d, g_d, b_d}, 24'hE0C090);
    run_to(kd(170, 30));    chk("d_sq17_dark", {r_d, g_d, b_d}, 24'h603010);

    run_to(ks(1, 0, 40));
    serialized_board = board2;
    select_loc       = {3'd5, 3'd5};
    turn             = 1'b0;

    run_to(ks(1, 103, 51)); chk("s_33_corner", {r_s, g_s, b_s}, 24'h603010);
    run_to(ks(1, 88, 54));  chk("s_23_cursor", {r_s, g_s, b_s}, 24'hFFFF00);
    run_to(ks(1, 94, 54));  chk("s_23_inner", {r_s, g_s, b_s}, 24'hE0C090);
    run_to(ks(1, 106, 54)); chk("s_33_king", {r_s, g_s, b_s}, 24'hFFB000);
    run_to(ks(1, 107, 54)); chk("s_33_king_rk", {r_s, g_s, b_s}, 24'hFFB000);
    run_to(ks(1, 108, 54)); chk("s_33_piece", {r_s, g_s, b_s}, 24'hC00000);
    run_to(ks(1, 107, 55)); chk("s_33_piece_d2", {r_s, g_s, b_s}, 24'hC00000);
    run_to(ks(1, 20, 60));  chk("s_bar_hold", {r_s, g_s, b_s}, 24'hC00000);
    run_to(ks(1, 70, 90));  chk("s_00_hold", {r_s, g_s, b_s}, 24'hC00000);

    // Frame 2: second snapshot picks up the mid-frame changes.
    run_to(ks(2, 20, 20));  chk("s_bar_white", {r_s, g_s, b_s}, 24'hF0F0F0);
    run_to(ks(2, 124, 30)); chk("s_55_cursor", {r_s, g_s, b_s}, 24'hFFFF00);
    run_to(ks(2, 88, 54));  chk("s_23_legal", {r_s, g_s, b_s}, 24'h00C000);
    run_to(ks(2, 70, 90));  chk("s_00_cleared", {r_s, g_s, b_s}, 24'h603010);

    // Reset asserted while the full-size raster sits at h=300.
    run_to(64 * 800 + 300);
    chk("d_vis_pre_rst", {23'd0, bn_d}, 24'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_sync_d", {21'd0, hs_d, vs_d, bn_d}, 24'h000006);
    chk("mid_rst_sync_s", {21'd0, hs_s, vs_s, bn_s}, 24'h000006);
    chk("mid_rst_rgb_s", {r_s, g_s, b_s}, 24'h000000);
    rst = 1'b0;
    cyc = 0;
    run_to(1); chk("post_rst_k1", {23'd0, bn_s}, 24'd0);
    run_to(2); chk("post_rst_k2", {23'd0, bn_s}, 24'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/checker_board_renderer.md
# checker_board_renderer

Display-side reader of the checkers game state. Consumes the 192-bit packed board, the 28-bit legal-move bus, the current selection and the turn flag, and drives a 640x480@60 Hz VGA raster. The board is drawn as an 8x8 grid with pieces, king markers, a cursor, legal-move highlights and a turn bar. Sits between the game-logic block and the board's VGA DAC pins.

## Interface
- `H_ORG`, default 80: first pixel column of the board area.
- `SQ`, default 60: square edge in pixels. The board spans 8*SQ = 480 pixels.
- `R_PIECE`, default 22: piece radius in pixels.
- `R_KING`, default 8: king-marker radius in pixels.
- `clk`  in  1  25 MHz pixel clock. This is the design's single clock.
- `rst`  in  1  Synchronous, active-high reset.
- `serialized_board`  in  192  Cell i occupies bits [3i+2:3i], where i = {x[2:0], y[2:0]}. Bit 2 = occupied, bit 1 = red, bit 0 = king.
- `legal_move`  in  28  Four 7-bit fields: {valid, x[2:0], y[2:0]}.
- `select_loc`  in  6  Cursor square, encoded {x, y}.
- `turn`  in  1  1 = red to move, 0 = white to move.
- `vga_r`, `vga_g`, `vga_b`  out  8 each  Pixel colour.
- `vga_hs`, `vga_vs`  out  1 each  Sync outputs, active low.
- `vga_blank_n`  out  1  High while the pixel is in the visible area.

## Operation
- **Counters.** `h` counts 0..799 and `v` counts 0..524. When `h` wraps at 799, `v` increments; `v` wraps at 524.
- **Sync.** `hs` is low for h in 656..751. `vs` is low for v in 490..491. Visible area is h<640 and v<480.
- **Snapshot.** At h=0, v=480, latch `serialized_board`, `legal_move`, `select_loc` and `turn` into frame registers. All drawing uses only the frame registers, so there is no mid-frame tearing. Reset loads all zeros into the snapshot.
- **Square mapping.** Pixels with H_ORG <= h < H_ORG+480 are board pixels.
  - Column sx and local offset dx come from a square-position counter (0..SQ-1, then sx+1). No divider is used.
  - Row sy and offset dy use the same scheme on `v`.
  - Board coordinate: x = sx, y = 7 - sy, so y=0 is the bottom row.
- **Colour priority, highest first:**
  - Cursor: outer 3 px border of square select_loc, yellow FF/FF/00.
  - Legal target: 3 px border of any square matching a valid legal_move field, green 00/C0/00.
  - King marker: piece present, king bit set, (dx-SQ/2)²+(dy-SQ/2)² <= R_KING², gold FF/B0/00.
  - Piece: occupied and distance² <= R_PIECE². Red → C0/00/00; white → F0/F0/F0.
  - Square: x+y even → dark 60/30/10; odd → light E0/C0/90.
- **Turn bar.** For h in 16..63 and v in 16..463, draw red C0/00/00 if the snapshot turn is 1, otherwise white F0/F0/F0.
- Every other visible pixel is black. Blanked pixels output 00/00/00.
- **Arithmetic.** Distance² is computed on signed 7-bit offsets giving an unsigned 12-bit square. Sum of squares is 13 bits. No truncation is permitted.

## Timing
- Two-stage pipeline.
  - Stage 1 registers sx, sy, dx, dy, region flags, and the 3-bit cell read from the snapshot.
  - Stage 2 registers the final RGB.
- `hs`, `vs` and `blank_n` are delayed 2 cycles to align with RGB. The pixel for counter value (h, v) appears at the outputs 2 cycles later together with its sync.
- Values after reset:
  - h = v = 0 and square counters = 0.
  - `vga_hs` = `vga_vs` = 1.
  - `vga_blank_n` = 0.
  - RGB = 0.
  - Pipeline registers are cleared.
- Reset mid-frame restarts counters at (0,0) on the next edge. There is no partial-line recovery. The first frame after reset draws an empty board with the turn bar white until the first snapshot at v=480.
- Input changes between snapshots have no visible effect.

## Structure
- Package `checker_pkg`:
  - Cell bit positions (OCC=2, RED=1, KING=0).
  - Legal-move field width (7) and count (4).
  - VGA timing constants (visible, front porch, sync, total for both h and v).
  - Colour constants.
- Sub-module `vga_timing`: h/v counters, raw hs/vs/visible, and the square and offset counters. The renderer instantiates it once.

## Test plan
- Reset held 3 cycles, then released → all outputs at reset values. The first `vga_hs` falling edge appears at cycle 656+2 after release; the line period is 800 cycles and the frame period is 420000 cycles.
- Opening board loaded, one frame run → the pixel at h=110, v=450 (square x=0, y=0, centre) is C0/00/00. At h=110, v=30 (x=0, y=7, empty, odd) it is E0/C0/90.
- Cell {3,3} = 3'b111 → the pixel at the square centre (h=290, v=270) is FF/B0/00. At offset dx=30+15 it is C0/00/00.
- legal_move[6:0] = {1, 3'd2, 3'd3} and select_loc = {3'd2, 3'd3} → the border pixel of square (2,3) is yellow (the cursor wins). With select_loc moved elsewhere, the same pixel is green.
- Change `serialized_board` at v=100 → output is unchanged for the rest of that frame and updates in the frame after v=480.
- `turn` toggles → the turn bar changes colour only after the next snapshot. Asserting `rst` mid-line at h=300 returns the outputs to reset values on the next edge.
